// File: rtl/secded_pkg.sv
// Shared FSM state, flag encoding and codeword size helpers for the
// SECDED stream decoder.
package secded_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_DEC  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    typedef logic [1:0] flag_t;

    localparam flag_t CLEAN = 2'b00;
    localparam flag_t SEC   = 2'b01;
    localparam flag_t DED   = 2'b10;

    function automatic int cw_bits(input int p);
        return 1 << p;
    endfunction

    function automatic int dw_bits(input int p);
        return (1 << p) - p - 1;
    endfunction

    function automatic int nb_bytes(input int p);
        return (1 << p) / 8;
    endfunction

    // Codeword position of data bit j (0-based): the j-th non-power-of-two position >= 3.
    function automatic int data_pos(input int j);
        int n;
        data_pos = 0;
        n        = 0;
        for (int i = 3; i < 64; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == j) data_pos = i;
                n++;
            end
        end
    endfunction

endpackage

// File: rtl/secded_dec.sv
// Combinational extended-Hamming decode: syndrome, overall parity,
// single-bit correction, classification flag and data extraction.
module secded_dec
    import secded_pkg::*;
#(
    parameter int P = 4
) (
    input  logic [cw_bits(P)-1:0] code,
    output flag_t                 flag,
    output logic [dw_bits(P)-1:0] data
);

    localparam int CW = cw_bits(P);
    localparam int DW = dw_bits(P);

    logic [P-1:0]  syn;
    logic          q;
    logic [CW-1:0] fixed;

    always_comb begin
        syn = '0;
        q   = 1'b0;
        for (int i = 0; i < CW; i++) begin
            if (code[i]) begin
                syn = syn ^ P'(i);
                q   = ~q;
            end
        end

        // Odd parity means a single flip at position syn; syn=0 is p0 itself.
        fixed = code;
        if (q) fixed[syn] = ~code[syn];

        if (q)               flag = SEC;
        else if (syn != '0)  flag = DED;
        else                 flag = CLEAN;

        data = '0;
        for (int j = 0; j < DW; j++) data[j] = fixed[data_pos(j)];
    end

endmodule

// File: rtl/secded_stream_decoder.sv
// Streams SECDED codewords from memory byte-by-byte, decodes each one and
// writes back {flag, zeros, data}, counting corrected and detected errors.
//
// state   | meaning
// IDLE    | waiting for start; done holds result of last run
// RD      | reading NB source bytes, LSB first
// DEC     | one cycle: decode buffered word, update counters
// WR      | writing NB result bytes, LSB first
module secded_stream_decoder
    import secded_pkg::*;
#(
    parameter int P      = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] count,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sec_cnt,
    output logic [7:0]        ded_cnt
);

    localparam int CW = cw_bits(P);
    localparam int DW = dw_bits(P);
    localparam int NB = nb_bytes(P);

    state_t            state, state_nxt;
    logic [2:0]        byte_idx;
    logic              last_byte;
    logic [ADDR_W-1:0] words_left;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [CW-1:0]     word_buf;
    logic [CW-1:0]     result;
    logic [CW-1:0]     result_word;
    flag_t             dec_flag;
    logic [DW-1:0]     dec_data;

    secded_dec #(.P(P)) u_dec (
        .code (word_buf),
        .flag (dec_flag),
        .data (dec_data)
    );

    assign last_byte = (byte_idx == 3'(NB - 1));

    always_comb begin
        result_word            = '0;
        result_word[CW-1 -: 2] = dec_flag;
        result_word[DW-1:0]    = dec_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = '0;
        case (state)
            ST_IDLE: if (start && count != '0) state_nxt = ST_RD;
            ST_RD: begin
                mem_addr = rd_addr;
                if (last_byte) state_nxt = ST_DEC;
            end
            ST_DEC: state_nxt = ST_WR;
            ST_WR: begin
                mem_we    = 1'b1;
                mem_wdata = result[7:0];
                mem_addr  = wr_addr;
                if (last_byte) state_nxt = (words_left == ADDR_W'(1)) ? ST_IDLE : ST_RD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx   <= '0;
            words_left <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            word_buf   <= '0;
            result     <= '0;
            done       <= 1'b0;
            sec_cnt    <= '0;
            ded_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    words_left <= count;
                    rd_addr    <= src_base;
                    wr_addr    <= dst_base;
                    byte_idx   <= '0;
                    done       <= (count == '0);
                    sec_cnt    <= '0;
                    ded_cnt    <= '0;
                end
                ST_RD: begin
                    word_buf <= {mem_rdata, word_buf[CW-1:8]};
                    rd_addr  <= rd_addr + ADDR_W'(1);
                    byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
                end
                ST_DEC: begin
                    result <= result_word;
                    if (dec_flag == SEC && sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
                    if (dec_flag == DED && ded_cnt != 8'hFF) ded_cnt <= ded_cnt + 8'd1;
                end
                ST_WR: begin
                    result   <= {8'h00, result[CW-1:8]};
                    wr_addr  <= wr_addr + ADDR_W'(1);
                    byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
                    if (last_byte) begin
                        words_left <= words_left - ADDR_W'(1);
                        if (words_left == ADDR_W'(1)) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/secded_stream_decoder.md
SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

Interface
REQ-001 SHALL have parameter P, default 4: Hamming parity-bit count excluding overall parity; legal values 4 and 5.
REQ-002 SHALL have parameter ADDR_W, default 8: byte-address width of the data memory.
REQ-003 SHALL derive CW = 2^P (codeword bits), DW = CW-P-1 (data bits) and NB = CW/8 (bytes per word); P=4 gives 16/11/2.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: request to run, sampled in IDLE only.
REQ-007 SHALL have port count  input  ADDR_W: number of codewords to process.
REQ-008 SHALL have port src_base  input  ADDR_W: byte address of the first corrupt codeword.
REQ-009 SHALL have port dst_base  input  ADDR_W: byte address of the first result word.
REQ-010 SHALL have port mem_addr  output  ADDR_W: memory byte address.
REQ-011 SHALL have port mem_rdata  input  8: memory read data, combinational, valid in the same cycle as mem_addr.
REQ-012 SHALL have port mem_we  output  1: memory write enable.
REQ-013 SHALL have port mem_wdata  output  8: memory write data.
REQ-014 SHALL have port busy  output  1: high while a run is in progress.
REQ-015 SHALL have port done  output  1: completion level.
REQ-016 SHALL have port sec_cnt  output  8: count of corrected single errors in the last run.
REQ-017 SHALL have port ded_cnt  output  8: count of detected double errors in the last run.

Function
REQ-018 SHALL place word i at byte address base+NB*i, least-significant byte at the lowest address; all address arithmetic wraps modulo 2^ADDR_W.
REQ-019 SHALL use codeword layout: bit 0 = overall parity; bits at positions 2^k = parity k; remaining positions hold data bits d1..dDW in ascending position order (P=4: d1 at 3, d2-d4 at 5-7, d5-d11 at 9-15).
REQ-020 SHALL compute syndrome s = XOR of the indices of all set bits in positions 1..CW-1, and q = XOR of all CW bits.
REQ-021 SHALL classify: s=0,q=0 -> flag 2'b00, data unchanged; q=1 -> flag 2'b01, flip bit s (s=0 means p0 only, data unchanged); s!=0,q=0 -> flag 2'b10, data left uncorrected.
REQ-022 SHALL write the result word {flag[1:0], zeros, data[DW:1]}, CW bits wide.
REQ-023 SHALL implement FSM IDLE -> RD (NB cycles, one byte per cycle) -> DEC (1 cycle) -> WR (NB cycles, mem_we high) -> RD for the next word, or -> IDLE after the last word.
REQ-024 SHALL take exactly 2*NB+1 cycles per word, with no idle cycles between words.
REQ-025 SHALL assert busy in every non-IDLE state.
REQ-026 SHALL assert mem_we only in WR; mem_wdata SHALL be 0 outside WR.
REQ-027 SHALL, on start accepted in IDLE, latch count/src_base/dst_base, clear done, sec_cnt and ded_cnt, and enter RD on the next cycle.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL, for count=0, perform no memory access, return to IDLE and raise done one cycle after acceptance.
REQ-030 SHALL raise done on the cycle after the last write and hold it until the next accepted start.
REQ-031 SHALL increment sec_cnt/ded_cnt in DEC for flags 01/10, saturating at 255.
REQ-032 SHALL leave input-port changes during a run without effect.

Reset
REQ-033 SHALL, on reset low at any time, asynchronously enter IDLE with busy, done, mem_we, mem_wdata, mem_addr, sec_cnt and ded_cnt at 0.
REQ-034 SHALL abandon a run interrupted by reset, issue no further writes, and leave partially written results as-is.

Structure
REQ-035 SHALL take the FSM state enum, the 2-bit flag type/constants (CLEAN, SEC, DED) and CW/DW/NB helper functions from package secded_pkg.
REQ-036 SHALL implement the combinational decode (syndrome, correction, flag, data extraction) in sub-module secded_dec, parametrised by P.

Verification
REQ-037 SHALL check P=4, src_base=30, dst_base=0, word 0xFFFF -> result 0x07FF, sec_cnt=0, ded_cnt=0.
REQ-038 SHALL check word 0x0020 (single flip of data bit at position 5) -> result 0x4000, sec_cnt=1.
REQ-039 SHALL check word 0xFFFE (p0 flipped) -> result 0x47FF.
REQ-040 SHALL check word 0x0028 (double error) -> result 0x8003, ded_cnt=1.
REQ-041 SHALL check 15 random words with 0/1/2 flips -> every result matches the model, done high 15*5+1 cycles after start, and count=0 raises done after 1 cycle with mem_we never high.
REQ-042 SHALL check reset pulsed low mid-WR of word 3 -> busy=0 and done=0 immediately, no subsequent mem_we, and a following run completes correctly; repeat scenario 1 with P=5 (NB=4, 9 cycles/word).
